alu_share_arbiter: RTL
======================

# alu_share_arbiter

Shares one combinational 16-bit ALU (2-bit opcode, 4-bit status flags) between up to eight requesters, such as the calculator FSM, a self-test sequencer and a UART command decoder. It arbitrates among pending requests and drives the ALU operand and opcode inputs from registers. It captures the result and flags one cycle later and returns them with a valid/ready handshake tagged by requester ID. One operation is in flight at a time.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `C_WIDTH`, default 16: operand and result width.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `req` input, `N_REQ` bits: per-requester request level.
- `req_a` input, `N_REQ*C_WIDTH` bits: operand A per requester; slice i belongs to requester i.
- `req_b` input, `N_REQ*C_WIDTH` bits: operand B per requester.
- `req_op` input, `N_REQ*2` bits: opcode per requester.
- `gnt` output, `N_REQ` bits: one-hot, single-cycle grant pulse.
- `alu_a`, `alu_b` output, `C_WIDTH` bits each: registered ALU operands.
- `alu_op` output, 2 bits: registered ALU opcode.
- `alu_res` input, `C_WIDTH` bits: ALU result.
- `alu_flags` input, 4 bits: ALU status flags.
- `rsp_valid` output, 1 bit: response valid.
- `rsp_ready` input, 1 bit: response accepted by the consumer.
- `rsp_id` output, `ID_W` bits: index of the requester that owns the response.
- `rsp_result` output, `C_WIDTH` bits: captured ALU result.
- `rsp_flags` output, 4 bits: captured ALU flags.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- **Reset values.** `state`=IDLE. `gnt`, `alu_a`, `alu_b`, `alu_op`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_flags` and `busy` are all 0. The round-robin pointer is `N_REQ-1`.
- **IDLE.** If `req` is non-zero, pick winner w on this edge.
  - Load `alu_a`/`alu_b`/`alu_op` from slice w.
  - `gnt` <= onehot(w); `rsp_id` <= w.
  - Update the pointer to w; go to EXEC.
  - If `req` is zero, stay in IDLE with every register held.
- **EXEC.** On this edge:
  - `rsp_result` <= `alu_res`; `rsp_flags` <= `alu_flags`.
  - `rsp_valid` <= 1; `gnt` <= 0; go to RESP.
- **RESP.** Hold `rsp_*` stable.
  - On an edge with `rsp_ready`=1: `rsp_valid` <= 0 and go to IDLE.
  - `alu_*` hold their values throughout RESP.
- **Arbitration.** Round-robin: search starts at pointer+1 and wraps modulo `N_REQ`. A requester that has just been served has the lowest priority for the next grant.
- **Requester contract.** A requester holds `req` and its operands until it samples `gnt[i]`=1, then deasserts `req` or presents a new operation. Requests raised while `busy`=1 wait; none are dropped.
- If a requester deasserts `req` before being granted, it is simply not served; no error is raised.
- The arbiter performs no arithmetic. Results and flags pass through at full width unmodified.

## Timing
- A request sampled in IDLE at edge k produces:
  - `gnt` high for exactly the cycle after edge k.
  - `alu_*` valid from edge k.
  - `rsp_valid` high from edge k+1.
- Best-case request-to-response latency is 2 edges. Best-case throughput is one operation per 3 cycles, with `rsp_ready` tied high.
- The response handshake completes on any edge where `rsp_valid && rsp_ready`. `rsp_ready` may be high early; it is ignored outside RESP.
- Reset has priority over all other events. Reset in EXEC or RESP discards the in-flight operation: no response is issued and the pointer returns to `N_REQ-1`.
- `gnt` is never asserted while `busy`=1 in the same cycle that a response is pending.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration as described above.
- `ALU_ARB_RR_EN` undefined: fixed priority, where the lowest index wins. The pointer register is removed and all other behaviour is identical.

## Test plan
- **Single request.** `req`=4'b0010, A=16'h0003, B=16'h0004, op=0, `rsp_ready`=1.
  - Required: `gnt`=4'b0010 for one cycle.
  - Required: `rsp_valid` 2 edges after the request, with `rsp_id`=1 and `rsp_result`/`rsp_flags` equal to the team ALU model output for those operands.
- **Round-robin.** `ALU_ARB_RR_EN` defined; `req`=4'b1111 held, with each requester re-requesting after its grant.
  - Required: grant order 0,1,2,3,0, one grant every 3 cycles.
- **Fixed priority.** `ALU_ARB_RR_EN` undefined; same stimulus as round-robin.
  - Required: requester 0 wins every time while it is requesting.
  - After `req[0]` drops: requester 1 is served.
- **Backpressure.** `rsp_ready`=0 for 5 cycles while `req[2]` is asserted.
  - Required: `rsp_*` stable and `busy`=1.
  - Required: no `gnt` to requester 2 until one edge after `rsp_ready` rises.
- **Reset mid-operation.** Assert `rst_n`=0 during EXEC.
  - Required: next cycle, all outputs are 0 and the state is IDLE.
  - Required: no `rsp_valid` pulse appears for the discarded operation.
- **Late request.** `req[3]` rises during RESP of requester 0.
  - Required: `req[3]` is granted on the first IDLE edge, with `rsp_id`=3.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU among N_REQ requesters (ALU_ARB_RR_EN selects round-robin)
module alu_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int C_WIDTH = 16,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*C_WIDTH-1:0] req_a,
  input  logic [N_REQ*C_WIDTH-1:0] req_b,
  input  logic [N_REQ*2-1:0]       req_op,
  output logic [N_REQ-1:0]         gnt,
  output logic [C_WIDTH-1:0]       alu_a,
  output logic [C_WIDTH-1:0]       alu_b,
  output logic [1:0]               alu_op,
  input  logic [C_WIDTH-1:0]       alu_res,
  input  logic [3:0]               alu_flags,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [C_WIDTH-1:0]       rsp_result,
  output logic [3:0]               rsp_flags,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [C_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [C_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [1:0]           alu_op_q, alu_op_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [C_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic [3:0]           rsp_flags_q, rsp_flags_d;

  logic [N_REQ-1:0]     pick_vec;
  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [N_REQ-1:0]     win_oh;
  logic [C_WIDTH-1:0]   win_a, win_b;
  logic [1:0]           win_op;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]     hi_mask;

  // Requesters above the last winner go first; if none is pending, wrap to the full set
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_mask[i] = (i > int'(ptr_q));
    end
    pick_vec = (|(req & hi_mask)) ? (req & hi_mask) : req;
  end
`else
  // Fixed priority: the lowest pending index always wins
  always_comb begin
    pick_vec = req;
  end
`endif

  // Lowest set bit of the candidate vector is the winner; capture its operands alongside
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    win_a     = '0;
    win_b     = '0;
    win_op    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && pick_vec[i]) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
        win_oh[i] = 1'b1;
        win_a     = req_a[i*C_WIDTH +: C_WIDTH];
        win_b     = req_b[i*C_WIDTH +: C_WIDTH];
        win_op    = req_op[i*2 +: 2];
      end
    end
  end

  // Next-state and register updates for the grant / execute / respond sequence
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
`ifdef ALU_ARB_RR_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          alu_a_d  = win_a;
          alu_b_d  = win_b;
          alu_op_d = win_op;
          gnt_d    = win_oh;
          rsp_id_d = win_id;
`ifdef ALU_ARB_RR_EN
          ptr_d    = win_id;
`endif
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_result_d = alu_res;
        rsp_flags_d  = alu_flags;
        rsp_valid_d  = 1'b1;
        gnt_d        = '0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
`ifdef ALU_ARB_RR_EN
      ptr_q        <= ID_W'(N_REQ - 1);
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
`ifdef ALU_ARB_RR_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != S_IDLE);

endmodule
